multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the add/sub/jump datapath. It fetches each instruction word through a request/acknowledge handshake with instruction memory, decodes the 6-bit opcode, and issues one-cycle strobes to the IR, register file, ALU and PC mux. It sits between instruction memory and the existing decode, sign-extend, shift, adder and jump-mux logic, and replaces their ad-hoc combinational sequencing.

## Interface
- TIMEOUT_CYCLES, 16: max cycles FETCH waits for imem_ack before trapping; legal range 1..255.
- OP_ADD, 6'b100000: add opcode.
- OP_SUB, 6'b100010: subtract opcode.
- OP_J, 6'b000010: jump opcode.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; high lets the controller leave IDLE and keep fetching.
- imem_req  out  1  fetch request; held high until ack.
- imem_ack  in  1  instruction word valid this cycle.
- instr  in  32  instruction word; sampled only when imem_req && imem_ack.
- ir_we  out  1  IR load strobe; asserted in the ack cycle.
- alu_op  out  1  0 = add, 1 = sub; valid in EXEC and WB.
- reg_we  out  1  register-file write strobe.
- pc_we  out  1  PC load strobe.
- pc_sel  out  1  0 = PC+4, 1 = jump target; meaningful only with pc_we.
- busy  out  1  high in every state except IDLE and TRAP.
- trap  out  1  sticky error flag.
- retired  out  32  count of completed instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, JUMP, TRAP.
- IDLE → FETCH when start = 1.
- FETCH: imem_req = 1.
  - On ack: capture instr[31:26] into op_q, pulse ir_we, go to DECODE.
  - Wait counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES without ack, go to TRAP.
- DECODE (1 cycle) branches on op_q:
  - OP_ADD → EXEC with alu_op = 0.
  - OP_SUB → EXEC with alu_op = 1.
  - OP_J → JUMP.
  - Any other opcode: see Configuration.
- EXEC (1 cycle) → WB. alu_op is held.
- WB (1 cycle): reg_we = 1, pc_we = 1, pc_sel = 0, retired += 1. Then FETCH if start = 1, else IDLE.
- JUMP (1 cycle): pc_we = 1, pc_sel = 1, retired += 1. Then FETCH if start = 1, else IDLE.
- TRAP: absorbing. trap = 1, all strobes 0. Only rst exits TRAP.
- start is sampled only in IDLE, WB and JUMP. Dropping start mid-instruction never aborts it.
- Strobes are registered state decodes. No strobe is ever asserted in two consecutive cycles.

## Timing
- Reset values: state = IDLE, imem_req = 0, ir_we = 0, reg_we = 0, pc_we = 0, pc_sel = 0, alu_op = 0, busy = 0, trap = 0, retired = 0, op_q = 0, wait counter = 0.
- Reset asserted mid-instruction: all outputs take their reset values immediately (asynchronously), and the in-flight instruction is not retired.
- Latency with ack in the first FETCH cycle:
  - add/sub: 4 cycles (FETCH, DECODE, EXEC, WB).
  - jump: 3 cycles (FETCH, DECODE, JUMP).
- Each cycle of ack delay adds one FETCH cycle.
- Wait counter clears on entry to FETCH.
- Ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins.
- imem_ack outside FETCH is ignored.
- retired wraps from 32'hFFFF_FFFF to 0 without trapping.

## Configuration
- ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE → TRAP. The instruction is not retired.
- ILLEGAL_TRAP_EN undefined: an unknown opcode is a NOP. DECODE → WB with reg_we forced to 0, pc_we = 1, pc_sel = 0, and it counts in retired.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enum.
  - OP_ADD, OP_SUB, OP_J opcode constants.
  - ALU_ADD = 0 and ALU_SUB = 1 constants.
- Sub-module `fetch_timer`: saturating wait counter with clear and a timeout flag output.
- Everything else lives in one FSM module.

## Test plan
- Reset, start = 1, ack in the first cycle, instr = 32'h8000_0000 (add) → ir_we at cycle 0, reg_we and pc_we at cycle 3 with pc_sel = 0 and alu_op = 0, retired = 1.
- instr = 32'h0800_0000 (jump), ack delayed 2 cycles → pc_we with pc_sel = 1 at cycle 4, reg_we never asserted, retired = 1.
- Sub opcode 6'b100010 followed by add, start held high → alu_op = 1 during the first EXEC/WB and 0 during the second, back-to-back FETCH with no IDLE cycle, retired = 2.
- imem_ack held 0 with TIMEOUT_CYCLES = 4 → trap = 1 and busy = 0 after 4 FETCH cycles, trap held through 20 further cycles, cleared only by rst.
- Opcode 6'b111111:
  - with ILLEGAL_TRAP_EN → trap = 1, retired = 0.
  - without ILLEGAL_TRAP_EN → pc_we = 1, reg_we = 0, retired = 1.
- rst pulsed during EXEC → all outputs at reset values within the reset cycle, retired = 0. After release with start = 1, FETCH resumes with imem_req = 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_JUMP,
        ST_TRAP
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_fetch_timer.sv
// Saturating FETCH wait counter; timeout_o flags that this un-acked cycle is the last one allowed.
// Latency: count updates one cycle after inc_i; timeout_o is combinational from the count.
// Backpressure: none; clr_i has priority over inc_i.
module fetch_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // True when one more un-acked cycle would make the count reach the limit.
    assign timeout_o = (({1'b0, cnt_q} + 9'd1) >= LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec sequencer for the add/sub/jump datapath; ILLEGAL_TRAP_EN traps unknown opcodes.
// Latency: add/sub 4 cycles, jump 3 cycles from first FETCH cycle, plus one per cycle of ack delay.
// Backpressure: imem_req held until imem_ack; FETCH traps after TIMEOUT_CYCLES un-acked cycles.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        ir_we,
    output logic        alu_op,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        busy,
    output logic        trap,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic        alu_q, alu_d;
    logic        nop_q, nop_d;
    logic [31:0] retired_q, retired_d;
    logic        timeout;
    logic        timer_clr;
    logic        timer_inc;
    logic        unused_instr;

    assign unused_instr = ^instr[25:0];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        alu_d     = alu_q;
        nop_d     = nop_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    op_d    = instr[31:26];
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                alu_d = ALU_ADD;
                nop_d = 1'b0;
                case (op_q)
                    OP_ADD: state_d = ST_EXEC;
                    OP_SUB: begin
                        alu_d   = ALU_SUB;
                        state_d = ST_EXEC;
                    end
                    OP_J:   state_d = ST_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        // Unknown opcode retires as a NOP: PC advances, no register write.
                        nop_d   = 1'b1;
                        state_d = ST_WB;
`endif
                    end
                endcase
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB, ST_JUMP: begin
                retired_d = retired_q + 32'd1;
                state_d   = start ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            alu_q     <= ALU_ADD;
            nop_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            alu_q     <= alu_d;
            nop_q     <= nop_d;
            retired_q <= retired_d;
        end
    end

    // Counter restarts on every entry to FETCH, including WB/JUMP -> FETCH.
    assign timer_clr = (state_d == ST_FETCH) && (state_q != ST_FETCH);
    assign timer_inc = (state_q == ST_FETCH) && !imem_ack;

    fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .inc_i    (timer_inc),
        .timeout_o(timeout)
    );

    assign imem_req = (state_q == ST_FETCH);
    assign ir_we    = (state_q == ST_FETCH) && imem_ack;
    assign reg_we   = (state_q == ST_WB) && !nop_q;
    assign pc_we    = (state_q == ST_WB) || (state_q == ST_JUMP);
    assign pc_sel   = (state_q == ST_JUMP);
    assign alu_op   = ((state_q == ST_EXEC) || (state_q == ST_WB)) ? alu_q : ALU_ADD;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign trap     = (state_q == ST_TRAP);
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT_CYCLES = 4); output vector is
// {imem_req, ir_we, reg_we, pc_we, pc_sel, alu_op, busy, trap}.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADD = 32'h8000_0000;
    localparam logic [31:0] I_SUB = 32'h8800_0000;
    localparam logic [31:0] I_J   = 32'h0800_0000;
    localparam logic [31:0] I_BAD = 32'hFC00_0000;

    localparam logic [7:0] V_IDLE   = 8'b0000_0000;
    localparam logic [7:0] V_FWAIT  = 8'b1000_0010;
    localparam logic [7:0] V_FACK   = 8'b1100_0010;
    localparam logic [7:0] V_BUSY   = 8'b0000_0010;
    localparam logic [7:0] V_EXSUB  = 8'b0000_0110;
    localparam logic [7:0] V_WBADD  = 8'b0011_0010;
    localparam logic [7:0] V_WBSUB  = 8'b0011_0110;
    localparam logic [7:0] V_WBNOP  = 8'b0001_0010;
    localparam logic [7:0] V_JUMP   = 8'b0001_1010;
    localparam logic [7:0] V_TRAP   = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_req, ir_we, alu_op, reg_we, pc_we, pc_sel, busy, trap;
    logic [31:0] retired;
    logic [7:0]  ov;

    int n_chk = 0;
    int n_err = 0;

    assign ov = {imem_req, ir_we, reg_we, pc_we, pc_sel, alu_op, busy, trap};

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .instr   (instr),
        .ir_we   (ir_we),
        .alu_op  (alu_op),
        .reg_we  (reg_we),
        .pc_we   (pc_we),
        .pc_sel  (pc_sel),
        .busy    (busy),
        .trap    (trap),
        .retired (retired)
    );

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        imem_ack = 1'b0;
        instr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Advance one clock, then drive this cycle's inputs and let outputs settle.
    task automatic cyc(input logic s, input logic a, input logic [31:0] w);
        @(posedge clk);
        #1;
        start = s;
        imem_ack = a;
        instr = w;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", ov, V_IDLE); end
        n_chk++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        do_reset();
        cyc(1'b0, 1'b1, I_ADD);
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL idle_ignores_ack got=%b exp=%b", ov, V_IDLE); end
    endtask

    task automatic test_add();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL add_idle got=%b exp=%b", ov, V_IDLE); end
        cyc(1'b1, 1'b1, I_ADD);
        n_chk++; if (ov !== V_FACK) begin n_err++; $display("FAIL add_fetch got=%b exp=%b", ov, V_FACK); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL add_decode got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL add_exec got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_WBADD) begin n_err++; $display("FAIL add_wb got=%b exp=%b", ov, V_WBADD); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL add_after got=%b exp=%b", ov, V_IDLE); end
        n_chk++; if (retired !== 32'd1) begin n_err++; $display("FAIL add_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_jump_delayed();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_FWAIT) begin n_err++; $display("FAIL jmp_fetch0 got=%b exp=%b", ov, V_FWAIT); end
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_FWAIT) begin n_err++; $display("FAIL jmp_fetch1 got=%b exp=%b", ov, V_FWAIT); end
        cyc(1'b1, 1'b1, I_J);
        n_chk++; if (ov !== V_FACK) begin n_err++; $display("FAIL jmp_fetch2 got=%b exp=%b", ov, V_FACK); end
        // Stray ack with a different word in DECODE must not reload the opcode.
        cyc(1'b0, 1'b1, I_ADD);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL jmp_decode got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_JUMP) begin n_err++; $display("FAIL jmp_jump got=%b exp=%b", ov, V_JUMP); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL jmp_after got=%b exp=%b", ov, V_IDLE); end
        n_chk++; if (retired !== 32'd1) begin n_err++; $display("FAIL jmp_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, I_SUB);
        n_chk++; if (ov !== V_FACK) begin n_err++; $display("FAIL b2b_fetch1 got=%b exp=%b", ov, V_FACK); end
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_EXSUB) begin n_err++; $display("FAIL b2b_exec_sub got=%b exp=%b", ov, V_EXSUB); end
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_WBSUB) begin n_err++; $display("FAIL b2b_wb_sub got=%b exp=%b", ov, V_WBSUB); end
        cyc(1'b1, 1'b1, I_ADD);
        n_chk++; if (ov !== V_FACK) begin n_err++; $display("FAIL b2b_fetch2 got=%b exp=%b", ov, V_FACK); end
        n_chk++; if (retired !== 32'd1) begin n_err++; $display("FAIL b2b_retired_mid got=%0d exp=1", retired); end
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL b2b_exec_add got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_WBADD) begin n_err++; $display("FAIL b2b_wb_add got=%b exp=%b", ov, V_WBADD); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (retired !== 32'd2) begin n_err++; $display("FAIL b2b_retired got=%0d exp=2", retired); end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, '0);
            n_chk++; if (ov !== V_FWAIT) begin n_err++; $display("FAIL tmo_fetch%0d got=%b exp=%b", i, ov, V_FWAIT); end
        end
        for (int i = 0; i < 21; i++) begin
            cyc(1'b1, 1'b1, I_ADD);
            n_chk++; if (ov !== V_TRAP) begin n_err++; $display("FAIL tmo_trap%0d got=%b exp=%b", i, ov, V_TRAP); end
        end
        rst = 1'b1;
        #1;
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL tmo_rst_clears got=%b exp=%b", ov, V_IDLE); end
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, I_ADD);
        n_chk++; if (ov !== V_FACK) begin n_err++; $display("FAIL lim_fetch got=%b exp=%b", ov, V_FACK); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL lim_decode got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_WBADD) begin n_err++; $display("FAIL lim_wb got=%b exp=%b", ov, V_WBADD); end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, I_BAD);
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL ill_decode got=%b exp=%b", ov, V_BUSY); end
        cyc(1'b0, 1'b0, '0);
`ifdef ILLEGAL_TRAP_EN
        n_chk++; if (ov !== V_TRAP) begin n_err++; $display("FAIL ill_trap got=%b exp=%b", ov, V_TRAP); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (retired !== 32'd0) begin n_err++; $display("FAIL ill_retired got=%0d exp=0", retired); end
`else
        n_chk++; if (ov !== V_WBNOP) begin n_err++; $display("FAIL ill_nop_wb got=%b exp=%b", ov, V_WBNOP); end
        cyc(1'b0, 1'b0, '0);
        n_chk++; if (retired !== 32'd1) begin n_err++; $display("FAIL ill_retired got=%0d exp=1", retired); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, I_J);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, I_ADD);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_BUSY) begin n_err++; $display("FAIL mid_exec got=%b exp=%b", ov, V_BUSY); end
        n_chk++; if (retired !== 32'd1) begin n_err++; $display("FAIL mid_retired_pre got=%0d exp=1", retired); end
        rst = 1'b1;
        #1;
        n_chk++; if (ov !== V_IDLE) begin n_err++; $display("FAIL mid_rst_outputs got=%b exp=%b", ov, V_IDLE); end
        n_chk++; if (retired !== 32'd0) begin n_err++; $display("FAIL mid_rst_retired got=%0d exp=0", retired); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, '0);
        n_chk++; if (ov !== V_FWAIT) begin n_err++; $display("FAIL mid_resume got=%b exp=%b", ov, V_FWAIT); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_jump_delayed();
        test_back_to_back();
        test_timeout();
        test_ack_at_limit();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
